// File: rtl/tank_level_model.sv
`default_nettype none
// ============================================================================
// Module   : tank_level_model
// Purpose  : Behavioural water-tank plant. A prescaled flow tick integrates the
//            valve/pump commands into a saturating volume, with L/M/H sensors.
// Options  : TANK_FAULT_INJECT_EN adds fault_sel_i sensor override.
// Revision : 1.0 - initial release
// ============================================================================
module tank_level_model #(
  parameter int LVL_W    = 8,
  parameter int CLK_DIV  = 4,
  parameter int CAP      = 200,
  parameter int TH_L     = 50,
  parameter int TH_M     = 100,
  parameter int TH_H     = 150,
  parameter int RATE_IN  = 5,
  parameter int RATE_VS  = 3,
  parameter int RATE_BS  = 2,
  parameter int INIT_LVL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             clr_flags_i,
  input  logic             ve_i,
  input  logic             vs_i,
  input  logic             bs_i,
`ifdef TANK_FAULT_INJECT_EN
  input  logic [1:0]       fault_sel_i,
`endif
  output logic             l_o,
  output logic             m_o,
  output logic             h_o,
  output logic [LVL_W-1:0] level_o,
  output logic             tick_o,
  output logic             overflow_o,
  output logic             dry_run_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW    = LVL_W + 2;

  localparam logic [CNT_W-1:0]     c_cnt_last = CNT_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0]     c_cap      = LVL_W'(CAP);
  localparam logic [LVL_W-1:0]     c_init     = LVL_W'(INIT_LVL);
  localparam logic [LVL_W-1:0]     c_th_l     = LVL_W'(TH_L);
  localparam logic [LVL_W-1:0]     c_th_m     = LVL_W'(TH_M);
  localparam logic [LVL_W-1:0]     c_th_h     = LVL_W'(TH_H);
  localparam logic signed [SW-1:0] c_cap_s    = SW'(CAP);
  localparam logic signed [SW-1:0] c_rate_in  = SW'(RATE_IN);
  localparam logic signed [SW-1:0] c_rate_vs  = SW'(RATE_VS);
  localparam logic signed [SW-1:0] c_rate_bs  = SW'(RATE_BS);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              tick_q, tick_d;
  logic              ovf_q, ovf_d;
  logic              dry_q, dry_d;
  logic              l_q, m_q, h_q;
  logic              tick_evt;
  logic signed [SW-1:0] net;
  logic signed [SW-1:0] sum;

  // Sequencing: run_i always wins; a step pulse is honoured only from STOP.
  always_comb begin
    state_d  = ST_STOP;
    cnt_d    = cnt_q;
    tick_evt = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (cnt_q == c_cnt_last) begin
          cnt_d    = '0;
          tick_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STEP: tick_evt = 1'b1;
      default: ;
    endcase
    if (run_i) begin
      state_d = ST_RUN;
    end else if ((state_q == ST_STOP) && step_i) begin
      state_d = ST_STEP;
    end
  end

  always_comb begin
    net = '0;
    if (ve_i) net = net + c_rate_in;
    if (vs_i) net = net - c_rate_vs;
    if (bs_i) net = net - c_rate_bs;
    sum = $signed({2'b00, level_q}) + net;
  end

  // Flags look at the pre-update volume; a balanced flow is a no-op.
  always_comb begin
    level_d = level_q;
    tick_d  = tick_evt;
    dry_d   = 1'b0;
    ovf_d   = ovf_q;
    if (clr_flags_i) ovf_d = 1'b0;
    if (tick_evt) begin
      if (sum[SW-1]) begin
        level_d = '0;
      end else if (sum > c_cap_s) begin
        level_d = c_cap;
      end else begin
        level_d = sum[LVL_W-1:0];
      end
      if ((net != '0) && ve_i && (level_q == c_cap)) ovf_d = 1'b1;
      dry_d = (net != '0) && (vs_i || bs_i) && (level_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      level_q <= c_init;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
      l_q     <= (c_init >= c_th_l);
      m_q     <= (c_init >= c_th_m);
      h_q     <= (c_init >= c_th_h);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
      l_q     <= (level_q >= c_th_l);
      m_q     <= (level_q >= c_th_m);
      h_q     <= (level_q >= c_th_h);
    end
  end

  assign level_o    = level_q;
  assign tick_o     = tick_q;
  assign overflow_o = ovf_q;
  assign dry_run_o  = dry_q;

`ifdef TANK_FAULT_INJECT_EN
  always_comb begin
    l_o = l_q;
    m_o = m_q;
    h_o = h_q;
    unique case (fault_sel_i)
      2'b01: l_o = 1'b0;
      2'b10: m_o = 1'b0;
      2'b11: begin
        l_o = 1'b1;
        m_o = 1'b1;
        h_o = 1'b1;
      end
      default: ;
    endcase
  end
`else
  assign l_o = l_q;
  assign m_o = m_q;
  assign h_o = h_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tank_level_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_level_model
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared every cycle against a behavioural tank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_level_model;

  localparam int CLK_DIV = 4;
  localparam int CAP     = 200;
  localparam int TH_L    = 50;
  localparam int TH_M    = 100;
  localparam int TH_H    = 150;
  localparam int INIT    = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0, step = 1'b0, clr = 1'b0;
  logic       ve = 1'b0, vs = 1'b0, bs = 1'b0;
  logic [1:0] fsel = 2'b00;
  logic       l_s, m_s, h_s, tick, ovf, dry;
  logic [7:0] level;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tank_level_model dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .step_i      (step),
    .clr_flags_i (clr),
    .ve_i        (ve),
    .vs_i        (vs),
    .bs_i        (bs),
`ifdef TANK_FAULT_INJECT_EN
    .fault_sel_i (fsel),
`endif
    .l_o         (l_s),
    .m_o         (m_s),
    .h_o         (h_s),
    .level_o     (level),
    .tick_o      (tick),
    .overflow_o  (ovf),
    .dry_run_o   (dry)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: volume, clocks accumulated while running, and mode
  // (0 stopped, 1 running, 2 single step).
  int m_lvl, m_acc, m_mode, m_old, m_net;
  bit m_tick, m_dry, m_ovf, m_l, m_m, m_h, m_evt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lvl = INIT; m_acc = 0; m_mode = 0;
      m_tick = 0; m_dry = 0; m_ovf = 0;
      m_l = (INIT >= TH_L); m_m = (INIT >= TH_M); m_h = (INIT >= TH_H);
    end else begin
      m_old = m_lvl;
      m_l = (m_old >= TH_L); m_m = (m_old >= TH_M); m_h = (m_old >= TH_H);
      m_evt = (m_mode == 2) || ((m_mode == 1) && (m_acc + 1 == CLK_DIV));
      if (m_mode == 1) m_acc = m_evt ? 0 : m_acc + 1;
      m_tick = m_evt;
      m_dry = 0;
      if (clr) m_ovf = 0;
      if (m_evt) begin
        m_net = (ve ? 5 : 0) - (vs ? 3 : 0) - (bs ? 2 : 0);
        if (m_net != 0 && ve && m_old == CAP) m_ovf = 1;
        m_dry = (m_net != 0) && (vs || bs) && (m_old == 0);
        m_lvl = m_old + m_net;
        if (m_lvl < 0) m_lvl = 0;
        if (m_lvl > CAP) m_lvl = CAP;
      end
      m_mode = run ? 1 : ((m_mode == 0 && step) ? 2 : 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (tick) ticks_seen++;
    if (cmp_en) begin
      chk("level", int'(level), m_lvl);
      chk("tick", int'(tick), int'(m_tick));
      chk("overflow", int'(ovf), int'(m_ovf));
      chk("dry_run", int'(dry), int'(m_dry));
      chk("L", int'(l_s), (fsel == 2'b11) ? 1 : (fsel == 2'b01) ? 0 : int'(m_l));
      chk("M", int'(m_s), (fsel == 2'b11) ? 1 : (fsel == 2'b10) ? 0 : int'(m_m));
      chk("H", int'(h_s), (fsel == 2'b11) ? 1 : int'(m_h));
    end
  end

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic do_step();
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    @(negedge clk);
  endtask

  int t0;
  bit fill;

  initial begin
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("reset level", int'(level), 0);
    chk("reset sensors", int'({l_s, m_s, h_s}), 0);
    chk("reset flags", int'({tick, ovf, dry}), 0);

    // Fill from empty while running: 10 ticks to reach TH_L.
    @(negedge clk); @(negedge clk);
    run = 1'b1; ve = 1'b1; rst_n = 1'b1;
    repeat (41) @(posedge clk);
    #1;
    chk("fill level@41", int'(level), 50);
    chk("fill tick@41", int'(tick), 1);
    chk("fill L@41", int'(l_s), 0);
    @(posedge clk); #1;
    chk("fill L@42", int'(l_s), 1);
    chk("fill M@42", int'(m_s), 0);

    repeat (180) @(negedge clk);
    chk("sat level", int'(level), 200);
    chk("ovf set", int'(ovf), 1);
    ve = 1'b0;
    repeat (8) @(negedge clk);
    chk("ovf sticky", int'(ovf), 1);
    clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    @(negedge clk);
    chk("ovf cleared", int'(ovf), 0);
    run = 1'b0;

    // Single steps.
    do_reset();
    ve = 1'b1;
    t0 = ticks_seen;
    repeat (3) do_step();
    @(negedge clk);
    chk("step level", int'(level), 15);
    chk("step tick count", ticks_seen - t0, 3);
    rst_n = 1'b0;
    #1 chk("async reset level", int'(level), 0);
    @(negedge clk) rst_n = 1'b1;

    // Drain through empty.
    repeat (2) do_step();
    ve = 1'b0; vs = 1'b1;
    repeat (2) do_step();
    chk("drain level 4", int'(level), 4);
    bs = 1'b1;
    do_step();
    chk("clamp level 0", int'(level), 0);
    chk("no dry yet", int'(dry), 0);
    do_step();
    chk("dry pulse", int'(dry), 1);
    chk("dry level", int'(level), 0);
    vs = 1'b0; bs = 1'b0;

    // Mixed flows.
    do_reset();
    ve = 1'b1;
    repeat (20) do_step();
    chk("mix start", int'(level), 100);
    vs = 1'b1;
    do_step();
    chk("mix +2 a", int'(level), 102);
    do_step();
    chk("mix +2 b", int'(level), 104);
    bs = 1'b1;
    do_step();
    chk("balanced level", int'(level), 104);
    chk("balanced flags", int'({ovf, dry}), 0);
    ve = 1'b0; vs = 1'b0; bs = 1'b0;

`ifdef TANK_FAULT_INJECT_EN
    do_reset();
    ve = 1'b1;
    repeat (24) do_step();
    ve = 1'b0;
    @(negedge clk);
    fsel = 2'b01;
    #1 chk("fault01 LMH", int'({l_s, m_s, h_s}), 3'b010);
    fsel = 2'b00;
    #1 chk("fault00 LMH", int'({l_s, m_s, h_s}), 3'b110);
    fsel = 2'b11;
    #1 chk("fault11 LMH", int'({l_s, m_s, h_s}), 3'b111);
    fsel = 2'b00;
`endif

    // Randomized traffic, alternating fill- and drain-biased phases.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 200 == 0) fill = ($urandom_range(0, 1) == 1);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      ve   = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      vs   = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      bs   = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; step = 1'b0; clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
